// File: rtl/mem_editor_ctrl.sv
// mem_editor_ctrl - front-panel memory editor for the CDEC board.
// Turns debounced key levels plus the slide switches into address-set,
// write, increment and decrement operations on the 256x8 program memory,
// and captures the read-back byte for the 7-segment display.
//
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   mode_edit       1 = editor owns memory, 0 = CPU run mode
//   key_adrs/write/inc/dec  debounced key levels, 1 = pressed
//   sw[7:0]         switch value
//   mem_rdata[7:0]  memory read data, one cycle after mem_adrs
//   mem_adrs[7:0]   current edit address (registered)
//   mem_wdata[7:0]  write data (registered)
//   mem_we          one-cycle write strobe (registered)
//   disp_data[7:0]  byte read back from mem_adrs (registered)
//   busy            high while the FSM is not idle
module mem_editor_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_edit,
  input  logic       key_adrs,
  input  logic       key_write,
  input  logic       key_inc,
  input  logic       key_dec,
  input  logic [7:0] sw,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_adrs,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic [7:0] disp_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, CAPTURE} state_t;

  state_t     state_q, state_d;
  logic [7:0] adrs_q, adrs_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic [7:0] disp_q, disp_d;
  logic       mode_q, mode_d;

  // Key bits: [0]=adrs [1]=write [2]=inc [3]=dec
  logic [3:0] keys;
  logic [3:0] sync1_q, sync2_q, hist_q;
  logic [3:0] evt;

  assign keys = {key_dec, key_inc, key_write, key_adrs};
  // Rising edge only; flops reset to 1 so a key held through reset is ignored.
  assign evt  = sync2_q & ~hist_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      hist_q  <= 4'hF;
    end else begin
      sync1_q <= keys;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      adrs_q  <= 8'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      disp_q  <= 8'h00;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      adrs_q  <= adrs_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      disp_q  <= disp_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adrs_d  = adrs_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    disp_d  = disp_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        // mode history only tracks in IDLE, so a rise during an operation
        // still triggers a refresh once the FSM returns here.
        mode_d = mode_edit;
        if (mode_edit) begin
          if (evt[0]) begin
            adrs_d  = sw;
            state_d = READ;
          end else if (evt[1]) begin
            wdata_d = sw;
            we_d    = 1'b1;
            state_d = WRITE;
          end else if (evt[2]) begin
            adrs_d  = adrs_q + 8'd1;
            state_d = READ;
          end else if (evt[3]) begin
            adrs_d  = adrs_q - 8'd1;
            state_d = READ;
          end else if (!mode_q) begin
            state_d = READ;  // entering edit mode: refresh the display
          end
        end
      end
      WRITE: begin
        adrs_d  = adrs_q + 8'd1;
        state_d = READ;
      end
      READ:    state_d = CAPTURE;
      CAPTURE: begin
        disp_d  = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_adrs  = adrs_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign disp_data = disp_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_editor_ctrl.sv
module tb_mem_editor_ctrl;
  logic       clock = 1'b0;
  logic       reset, mode_edit;
  logic       key_adrs, key_write, key_inc, key_dec;
  logic [7:0] sw, mem_rdata, mem_adrs, mem_wdata, disp_data;
  logic       mem_we, busy;

  logic [7:0] mem [256];
  logic       pre_we;
  logic [7:0] pre_a, pre_d;
  int         n_chk = 0;
  int         n_fail = 0;
  int         we_cnt = 0;

  always #5 clock = ~clock;

  mem_editor_ctrl dut (
    .clock(clock), .reset(reset), .mode_edit(mode_edit),
    .key_adrs(key_adrs), .key_write(key_write), .key_inc(key_inc), .key_dec(key_dec),
    .sw(sw), .mem_rdata(mem_rdata), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .disp_data(disp_data), .busy(busy)
  );

  // Memory model: synchronous write, registered read (one-cycle latency)
  always @(posedge clock) begin
    if (mem_we) mem[mem_adrs] <= mem_wdata;
    else if (pre_we) mem[pre_a] <= pre_d;
    mem_rdata <= mem[mem_adrs];
  end

  always @(posedge clock) if (mem_we === 1'b1) we_cnt++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mode_edit = 1'b1; sw = 8'h00; pre_we = 1'b0;
    pre_a = 8'h00; pre_d = 8'h00;
    key_adrs = 0; key_write = 0; key_inc = 0; key_dec = 0;
    // Memory pattern mem[a] = a ^ C3, with mem[3C] = A5
    for (int a = 0; a < 256; a++) preload(8'(a), 8'(a) ^ 8'hC3);
    preload(8'h3C, 8'hA5);
    tick(2);
    chk("rst_adrs", mem_adrs, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_we", {7'd0, mem_we}, 8'h00);
    chk("rst_disp", disp_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);

    // Release reset with key_inc held: no event
    key_inc = 1'b1;
    tick();
    reset = 1'b0;
    tick(5);
    chk("hold_adrs", mem_adrs, 8'h00);
    chk("hold_busy", {7'd0, busy}, 8'h00);
    key_inc = 1'b0;
    tick(4);

    // Set address 3C
    sw = 8'h3C; key_adrs = 1'b1;
    tick();                 // N
    key_adrs = 1'b0;
    tick();                 // N+1
    chk("set_busy_n1", {7'd0, busy}, 8'h00);
    tick();                 // N+2
    chk("set_adrs", mem_adrs, 8'h3C);
    chk("set_busy_n2", {7'd0, busy}, 8'h01);
    tick();
    chk("set_busy_n3", {7'd0, busy}, 8'h01);
    tick();                 // N+4
    chk("set_busy_n4", {7'd0, busy}, 8'h00);
    chk("set_disp", disp_data, 8'hA5);
    tick(2);

    // Move to FF, then write 5A with wrap
    sw = 8'hFF; key_adrs = 1'b1; tick(); key_adrs = 1'b0; tick(5);
    chk("ff_adrs", mem_adrs, 8'hFF);
    sw = 8'h5A; key_write = 1'b1;
    tick();                 // N
    key_write = 1'b0;
    tick(2);                // N+2
    chk("wr_we", {7'd0, mem_we}, 8'h01);
    chk("wr_wdata", mem_wdata, 8'h5A);
    chk("wr_adrs_old", mem_adrs, 8'hFF);
    tick();                 // N+3
    chk("wr_we_off", {7'd0, mem_we}, 8'h00);
    chk("wr_adrs_inc", mem_adrs, 8'h00);
    chk("wr_mem", mem[8'hFF], 8'h5A);
    tick();
    chk("wr_busy_n4", {7'd0, busy}, 8'h01);
    tick();                 // N+5
    chk("wr_busy_n5", {7'd0, busy}, 8'h00);
    chk("wr_disp", disp_data, 8'hC3);
    chk("wr_pulses", 8'(we_cnt), 8'd1);
    tick(2);

    // Decrement wrap, then increment back
    key_dec = 1'b1; tick(); key_dec = 1'b0; tick(2);
    chk("dec_adrs", mem_adrs, 8'hFF);
    tick(2);
    chk("dec_disp", disp_data, 8'h5A);
    tick(2);
    key_inc = 1'b1; tick(); key_inc = 1'b0; tick(2);
    chk("inc_adrs", mem_adrs, 8'h00);
    tick(2);
    chk("inc_disp", disp_data, 8'hC3);
    tick(2);

    // Simultaneous adrs + inc: adrs wins
    sw = 8'h10; key_adrs = 1'b1; key_inc = 1'b1;
    tick(); key_adrs = 1'b0; key_inc = 1'b0; tick(2);
    chk("prio_adrs", mem_adrs, 8'h10);
    tick(2);
    chk("prio_disp", disp_data, 8'hD3);
    tick(2);

    // inc edge arriving while busy is dropped
    sw = 8'h20; key_adrs = 1'b1;
    tick();                 // N
    key_adrs = 1'b0; key_inc = 1'b1;
    tick();                 // N+1: inc first sampled, event at N+3 (busy)
    key_inc = 1'b0;
    tick(6);
    chk("busy_drop_adrs", mem_adrs, 8'h20);
    chk("busy_drop_busy", {7'd0, busy}, 8'h00);
    chk("busy_drop_disp", disp_data, 8'hE3);

    // Mode gating
    mode_edit = 1'b0;
    tick(2);
    preload(8'h20, 8'h77);
    key_write = 1'b1; tick(); key_write = 1'b0; tick(5);
    key_inc = 1'b1; tick(); key_inc = 1'b0; tick(5);
    chk("gate_pulses", 8'(we_cnt), 8'd1);
    chk("gate_adrs", mem_adrs, 8'h20);
    chk("gate_busy", {7'd0, busy}, 8'h00);
    mode_edit = 1'b1;
    tick();
    chk("refresh_busy", {7'd0, busy}, 8'h01);
    chk("refresh_adrs", mem_adrs, 8'h20);
    tick(2);
    chk("refresh_disp", disp_data, 8'h77);
    chk("refresh_idle", {7'd0, busy}, 8'h00);
    tick(3);
    chk("refresh_once", {7'd0, busy}, 8'h00);
    chk("final_pulses", 8'(we_cnt), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
